gate_drive_sequencer: RTL and testbench

//  Supervisory controller wrapped around the half-bridge dead-time core. It sequences power-up
//  (bootstrap precharge, arm, run), stop and fault shutdown. It feeds the core's pwm input and

---
 rtl/gate_drive_sequencer_if.sv | 31 +++
 rtl/gate_drive_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_gate_drive_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_drive_sequencer_if.sv
// Signal bundle between the gate-drive sequencer and its environment: control inputs,
// the dead-time core link, and the driver-pin gate outputs.
interface gate_drive_sequencer_if #(
    parameter int N = 12
);
    logic         enable;
    logic         pwm_cmd;
    logic         fault_in;
    logic         fault_clr;
    logic [N-1:0] dt_cfg;
    logic         dt_cfg_wr;
    logic [1:0]   core_pwm;
    logic         core_pwm_in;
    logic [N-1:0] core_dt;
    logic         gate_hi;
    logic         gate_lo;
    logic [2:0]   state;
    logic [1:0]   fault_code;
    logic         busy;

    // Environment side: drives the controls and returns the core's gate requests.
    modport master (
        output enable, pwm_cmd, fault_in, fault_clr, dt_cfg, dt_cfg_wr, core_pwm,
        input  core_pwm_in, core_dt, gate_hi, gate_lo, state, fault_code, busy
    );

    modport slave (
        input  enable, pwm_cmd, fault_in, fault_clr, dt_cfg, dt_cfg_wr, core_pwm,
        output core_pwm_in, core_dt, gate_hi, gate_lo, state, fault_code, busy
    );
endinterface

// File: rtl/gate_drive_sequencer.sv
// Supervisory sequencer around a half-bridge dead-time core: precharge, arm, run, stop, fault.
// Optional build macro GDS_WATCHDOG_EN adds a pwm_cmd activity watchdog in RUN.
module gate_drive_sequencer #(
    parameter int N          = 12,
    parameter int BOOT_CLKS  = 1000,
    parameter int DT_MIN     = 8,
    parameter int DT_DEFAULT = 50,
    parameter int WDOG_CLKS  = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    gate_drive_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BOOT  = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        STOP  = 3'd4,
        FAULT = 3'd5
    } state_t;

    // Counter must cover both the precharge length and the longest settle (dt+2).
    localparam int CNT_W = ($clog2(BOOT_CLKS + 1) > N + 1) ? $clog2(BOOT_CLKS + 1) : N + 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CLKS - 1);
    localparam logic [N-1:0]     DT_MIN_V  = N'(DT_MIN);
    localparam logic [N-1:0]     DT_DEF_V  = N'(DT_DEFAULT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gateHi;
    logic             r_gateLo;
    logic             r_corePwmIn;
    logic [N-1:0]     r_coreDt;
    logic [N-1:0]     r_shadow;
    logic [1:0]       r_faultCode;

    state_t           w_stateNext;
    logic [1:0]       w_faultCodeNext;
    logic             w_shoot;
    logic             w_bootDone;
    logic             w_settleDone;
    logic             w_wdogTrip;
    logic             w_stayRun;
    logic             w_gateHiNext;
    logic             w_gateLoNext;
    logic             w_corePwmInNext;
    logic [N-1:0]     w_dtClamped;
    logic [N-1:0]     w_shadowNext;
    logic             w_applyDt;

    assign w_shoot      = (r_state == RUN) && (bus.core_pwm == 2'b11);
    assign w_bootDone   = (r_cnt == BOOT_LAST);
    assign w_settleDone = (r_cnt == (CNT_W'(r_coreDt) + CNT_W'(1)));

`ifdef GDS_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CLKS + 1);

    logic [WD_W-1:0] r_wdogCnt;
    logic            r_pwmPrev;
    logic            w_toggle;

    assign w_toggle   = (bus.pwm_cmd != r_pwmPrev);
    assign w_wdogTrip = (r_state == RUN) && !w_toggle && (r_wdogCnt == WD_W'(WDOG_CLKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdogCnt <= '0;
            r_pwmPrev <= 1'b0;
        end else begin
            r_pwmPrev <= bus.pwm_cmd;
            if ((r_state != RUN) || w_toggle) begin
                r_wdogCnt <= '0;
            end else begin
                r_wdogCnt <= r_wdogCnt + WD_W'(1);
            end
        end
    end
`else
    localparam int unusedWdogClks = WDOG_CLKS;

    assign w_wdogTrip = 1'b0;
`endif

    // Fault causes pre-empt normal sequencing; the first cause is what gets latched.
    always_comb begin
        w_stateNext     = r_state;
        w_faultCodeNext = r_faultCode;
        if ((r_state != FAULT) && bus.fault_in) begin
            w_stateNext     = FAULT;
            w_faultCodeNext = 2'd1;
        end else if (w_shoot) begin
            w_stateNext     = FAULT;
            w_faultCodeNext = 2'd2;
        end else if (w_wdogTrip) begin
            w_stateNext     = FAULT;
            w_faultCodeNext = 2'd3;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.enable) w_stateNext = BOOT;
                end
                BOOT: begin
                    if (!bus.enable)     w_stateNext = STOP;
                    else if (w_bootDone) w_stateNext = ARM;
                end
                ARM: begin
                    if (!bus.enable)       w_stateNext = STOP;
                    else if (w_settleDone) w_stateNext = RUN;
                end
                RUN: begin
                    if (!bus.enable) w_stateNext = STOP;
                end
                STOP: begin
                    if (w_settleDone) w_stateNext = IDLE;
                end
                FAULT: begin
                    if (bus.fault_clr && !bus.fault_in && !bus.enable) begin
                        w_stateNext     = IDLE;
                        w_faultCodeNext = 2'd0;
                    end
                end
                default: begin
                    w_stateNext     = IDLE;
                    w_faultCodeNext = 2'd0;
                end
            endcase
        end
    end

    // Gates only follow the core while staying in RUN, so any exit forces both low on that edge.
    always_comb begin
        w_stayRun       = (r_state == RUN) && (w_stateNext == RUN);
        w_gateHiNext    = w_stayRun && bus.core_pwm[0];
        w_gateLoNext    = (w_stateNext == BOOT) || (w_stayRun && bus.core_pwm[1]);
        w_corePwmInNext = (w_stateNext == RUN) && bus.pwm_cmd;
    end

    // A new dead time reaches the core only when it cannot cut into an active deadband.
    always_comb begin
        w_dtClamped  = (bus.dt_cfg < DT_MIN_V) ? DT_MIN_V : bus.dt_cfg;
        w_shadowNext = bus.dt_cfg_wr ? w_dtClamped : r_shadow;
        w_applyDt    = (r_state == IDLE) || (r_state == FAULT) ||
                       ((w_stateNext == RUN) && bus.pwm_cmd && !r_corePwmIn);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gateHi    <= 1'b0;
            r_gateLo    <= 1'b0;
            r_corePwmIn <= 1'b0;
            r_coreDt    <= DT_DEF_V;
            r_shadow    <= DT_DEF_V;
            r_faultCode <= 2'd0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= (w_stateNext != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_gateHi    <= w_gateHiNext;
            r_gateLo    <= w_gateLoNext;
            r_corePwmIn <= w_corePwmInNext;
            r_shadow    <= w_shadowNext;
            r_faultCode <= w_faultCodeNext;
            if (w_applyDt) begin
                r_coreDt <= w_shadowNext;
            end
        end
    end

    assign bus.gate_hi     = r_gateHi;
    assign bus.gate_lo     = r_gateLo;
    assign bus.core_pwm_in = r_corePwmIn;
    assign bus.core_dt     = r_coreDt;
    assign bus.state       = r_state;
    assign bus.fault_code  = r_faultCode;
    assign bus.busy        = (r_state != IDLE) && (r_state != FAULT);

endmodule

// File: tb/tb_gate_drive_sequencer.sv
// Directed bench for gate_drive_sequencer with a behavioural dead-time core in the loop.
// Expectations for the watchdog follow the GDS_WATCHDOG_EN build macro.
module tb_gate_drive_sequencer;

    localparam int N          = 12;
    localparam int BOOT_CLKS  = 10;
    localparam int DT_MIN     = 8;
    localparam int DT_DEFAULT = 50;
    localparam int WDOG_CLKS  = 100;

    logic clk = 1'b0;
    logic reset;
    logic forceBoth;
    int   checks = 0;
    int   fails  = 0;

    gate_drive_sequencer_if #(.N(N)) bus ();

    gate_drive_sequencer #(
        .N(N), .BOOT_CLKS(BOOT_CLKS), .DT_MIN(DT_MIN),
        .DT_DEFAULT(DT_DEFAULT), .WDOG_CLKS(WDOG_CLKS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Dead-time core model: on a pwm change both requests drop, the new side asserts after core_dt clks.
    logic modelHi, modelLo, modelLast;
    int   modelCnt;

    always @(posedge clk) begin
        if (reset) begin
            modelHi <= 1'b0; modelLo <= 1'b0; modelLast <= 1'b0; modelCnt <= 0;
        end else if (bus.core_pwm_in != modelLast) begin
            modelLast <= bus.core_pwm_in; modelHi <= 1'b0; modelLo <= 1'b0; modelCnt <= 1;
        end else if (modelCnt < int'(bus.core_dt)) begin
            modelCnt <= modelCnt + 1;
        end else begin
            modelHi <= modelLast; modelLo <= !modelLast;
        end
    end

    assign bus.core_pwm = forceBoth ? 2'b11 : {modelLo, modelHi};

    task automatic goToRun(input string tag);
        bit reached = 0;
        bus.pwm_cmd = 1'b0;
        bus.enable  = 1'b1;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (bus.state == 3'd3) reached = 1;
        end
        checks++;
        if (!reached) begin fails++; $display("[TB] FAIL %s_reach_run: got state %0d, expected 3", tag, bus.state); end
    endtask

    task automatic clearFault();
        bus.enable = 1'b0; bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.state !== 3'd0)      begin fails++; $display("[TB] FAIL reset_state: got %0d, expected 0", bus.state); end
        if (bus.gate_hi !== 1'b0)    begin fails++; $display("[TB] FAIL reset_gate_hi: got %0b, expected 0", bus.gate_hi); end
        if (bus.gate_lo !== 1'b0)    begin fails++; $display("[TB] FAIL reset_gate_lo: got %0b, expected 0", bus.gate_lo); end
        if (bus.core_pwm_in !== 1'b0) begin fails++; $display("[TB] FAIL reset_core_pwm_in: got %0b, expected 0", bus.core_pwm_in); end
        if (bus.fault_code !== 2'd0) begin fails++; $display("[TB] FAIL reset_fault_code: got %0d, expected 0", bus.fault_code); end
        if (bus.busy !== 1'b0)       begin fails++; $display("[TB] FAIL reset_busy: got %0b, expected 0", bus.busy); end
        if (bus.core_dt !== 12'd50)  begin fails++; $display("[TB] FAIL reset_core_dt: got %0d, expected 50", bus.core_dt); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dt_clamp();
        bus.dt_cfg = 12'd3; bus.dt_cfg_wr = 1'b1;
        @(negedge clk);
        bus.dt_cfg_wr = 1'b0;
        checks++;
        if (bus.core_dt !== 12'd8) begin fails++; $display("[TB] FAIL dt_clamp: got %0d, expected 8", bus.core_dt); end
    endtask

    task automatic test_boot();
        int loCount = 0, armCount = 0, hiSeen = 0;
        bit reached = 0;
        bus.enable = 1'b1;
        for (int i = 0; i < 60 && !reached; i++) begin
            @(negedge clk);
            if (bus.state == 3'd3) reached = 1;
            else begin
                if (bus.gate_hi) hiSeen++;
                if (bus.gate_lo) loCount++;
                if (bus.state == 3'd2 && !bus.gate_lo && !bus.gate_hi && !bus.core_pwm_in) armCount++;
            end
        end
        checks += 4;
        if (loCount != 10) begin fails++; $display("[TB] FAIL boot_lo_clks: got %0d, expected 10", loCount); end
        if (armCount != 10) begin fails++; $display("[TB] FAIL arm_clks: got %0d, expected 10", armCount); end
        if (hiSeen != 0)   begin fails++; $display("[TB] FAIL boot_hi_seen: got %0d, expected 0", hiSeen); end
        if (!reached)      begin fails++; $display("[TB] FAIL boot_to_run: got state %0d, expected 3", bus.state); end
    endtask

    task automatic test_pwm_deadtime();
        int overlaps = 0, transitions = 0, minGap = 1000, gapLen = 0, lastOn = 2, cur;
        bus.dt_cfg = 12'd20; bus.dt_cfg_wr = 1'b1;
        @(negedge clk);
        bus.dt_cfg_wr = 1'b0;
        checks++;
        if (bus.core_dt !== 12'd8) begin fails++; $display("[TB] FAIL dt_held_before_rise: got %0d, expected 8", bus.core_dt); end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.gate_hi && bus.gate_lo) overlaps++;
            if (bus.gate_hi || bus.gate_lo) begin
                cur = bus.gate_hi ? 1 : 2;
                if (cur != lastOn) begin
                    transitions++;
                    if (gapLen < minGap) minGap = gapLen;
                end
                lastOn = cur; gapLen = 0;
            end else begin
                gapLen++;
            end
            bus.pwm_cmd = ((i % 200) < 100);
        end
        checks += 5;
        if (overlaps != 0)     begin fails++; $display("[TB] FAIL pwm_overlap: got %0d, expected 0", overlaps); end
        if (minGap < 20)       begin fails++; $display("[TB] FAIL pwm_min_gap: got %0d, expected >= 20", minGap); end
        if (transitions != 6)  begin fails++; $display("[TB] FAIL pwm_transitions: got %0d, expected 6", transitions); end
        if (bus.state !== 3'd3) begin fails++; $display("[TB] FAIL pwm_state: got %0d, expected 3", bus.state); end
        if (bus.core_dt !== 12'd20) begin fails++; $display("[TB] FAIL pwm_core_dt: got %0d, expected 20", bus.core_dt); end
    endtask

    task automatic test_dt_shadow();
        bus.pwm_cmd = 1'b1;
        repeat (31) @(negedge clk);
        bus.dt_cfg = 12'd40; bus.dt_cfg_wr = 1'b1;
        @(negedge clk);
        bus.dt_cfg_wr = 1'b0;
        checks++;
        if (bus.core_dt !== 12'd20) begin fails++; $display("[TB] FAIL dt_mid_pulse: got %0d, expected 20", bus.core_dt); end
        repeat (20) @(negedge clk);
        bus.pwm_cmd = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (bus.core_dt !== 12'd20) begin fails++; $display("[TB] FAIL dt_after_fall: got %0d, expected 20", bus.core_dt); end
        bus.pwm_cmd = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.core_dt !== 12'd40) begin fails++; $display("[TB] FAIL dt_at_rise: got %0d, expected 40", bus.core_dt); end
        repeat (50) @(negedge clk);
    endtask

    task automatic test_stop();
        int stopCount = 0;
        int endState  = -1;
        bit done = 0;
        bus.enable = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks += 3;
                if (bus.state !== 3'd4) begin fails++; $display("[TB] FAIL stop_entry: got %0d, expected 4", bus.state); end
                if (bus.gate_hi || bus.gate_lo) begin fails++; $display("[TB] FAIL stop_gates: got %0b%0b, expected 00", bus.gate_hi, bus.gate_lo); end
                if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL stop_busy: got %0b, expected 1", bus.busy); end
            end
            if (bus.state == 3'd4) begin
                stopCount++;
                if (i == 10) bus.enable = 1'b1;
            end else begin
                done = 1; endState = int'(bus.state);
            end
        end
        bus.enable = 1'b0;
        checks += 2;
        if (stopCount != 42) begin fails++; $display("[TB] FAIL stop_clks: got %0d, expected 42", stopCount); end
        if (endState != 0)   begin fails++; $display("[TB] FAIL stop_to_idle: got %0d, expected 0", endState); end
        @(negedge clk);
    endtask

    task automatic test_fault_external();
        goToRun("ext");
        repeat (30) @(negedge clk);
        bus.pwm_cmd = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (bus.gate_hi !== 1'b1) begin fails++; $display("[TB] FAIL ext_pre_gate_hi: got %0b, expected 1", bus.gate_hi); end
        bus.fault_in = 1'b1;
        @(negedge clk);
        bus.fault_in = 1'b0;
        checks += 5;
        if (bus.state !== 3'd5) begin fails++; $display("[TB] FAIL ext_state: got %0d, expected 5", bus.state); end
        if (bus.gate_hi || bus.gate_lo) begin fails++; $display("[TB] FAIL ext_gates: got %0b%0b, expected 00", bus.gate_hi, bus.gate_lo); end
        if (bus.fault_code !== 2'd1) begin fails++; $display("[TB] FAIL ext_code: got %0d, expected 1", bus.fault_code); end
        if (bus.core_pwm_in !== 1'b0) begin fails++; $display("[TB] FAIL ext_core_pwm_in: got %0b, expected 0", bus.core_pwm_in); end
        if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL ext_busy: got %0b, expected 0", bus.busy); end
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        checks++;
        if (bus.state !== 3'd5) begin fails++; $display("[TB] FAIL ext_clr_enabled: got %0d, expected 5", bus.state); end
        clearFault();
        checks += 2;
        if (bus.state !== 3'd0) begin fails++; $display("[TB] FAIL ext_clr_state: got %0d, expected 0", bus.state); end
        if (bus.fault_code !== 2'd0) begin fails++; $display("[TB] FAIL ext_clr_code: got %0d, expected 0", bus.fault_code); end
    endtask

    task automatic test_shoot_through();
        goToRun("st");
        repeat (50) @(negedge clk);
        forceBoth = 1'b1;
        @(negedge clk);
        forceBoth = 1'b0;
        checks += 3;
        if (bus.state !== 3'd5) begin fails++; $display("[TB] FAIL st_state: got %0d, expected 5", bus.state); end
        if (bus.gate_hi || bus.gate_lo) begin fails++; $display("[TB] FAIL st_gates: got %0b%0b, expected 00", bus.gate_hi, bus.gate_lo); end
        if (bus.fault_code !== 2'd2) begin fails++; $display("[TB] FAIL st_code: got %0d, expected 2", bus.fault_code); end
        clearFault();
        goToRun("st_prio");
        repeat (50) @(negedge clk);
        forceBoth = 1'b1; bus.fault_in = 1'b1;
        @(negedge clk);
        forceBoth = 1'b0; bus.fault_in = 1'b0;
        checks += 2;
        if (bus.state !== 3'd5) begin fails++; $display("[TB] FAIL prio_state: got %0d, expected 5", bus.state); end
        if (bus.fault_code !== 2'd1) begin fails++; $display("[TB] FAIL prio_code: got %0d, expected 1", bus.fault_code); end
        clearFault();
    endtask

    task automatic test_watchdog();
        int tripAt = -1;
        goToRun("wd");
        bus.pwm_cmd = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tripAt < 0 && bus.state == 3'd5) tripAt = i;
        end
`ifdef GDS_WATCHDOG_EN
        checks += 2;
        if (tripAt < 95 || tripAt > 105) begin fails++; $display("[TB] FAIL wd_trip_clk: got %0d, expected about 100", tripAt); end
        if (bus.fault_code !== 2'd3) begin fails++; $display("[TB] FAIL wd_code: got %0d, expected 3", bus.fault_code); end
`else
        checks += 2;
        if (tripAt != -1) begin fails++; $display("[TB] FAIL wd_absent_trip: got %0d, expected -1", tripAt); end
        if (bus.state !== 3'd3) begin fails++; $display("[TB] FAIL wd_absent_state: got %0d, expected 3", bus.state); end
`endif
        clearFault();
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        goToRun("rst");
        bus.pwm_cmd = 1'b1;
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.state !== 3'd0) begin fails++; $display("[TB] FAIL midrst_state: got %0d, expected 0", bus.state); end
        if (bus.gate_hi || bus.gate_lo) begin fails++; $display("[TB] FAIL midrst_gates: got %0b%0b, expected 00", bus.gate_hi, bus.gate_lo); end
        if (bus.core_dt !== 12'd50) begin fails++; $display("[TB] FAIL midrst_core_dt: got %0d, expected 50", bus.core_dt); end
        if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %0b, expected 0", bus.busy); end
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        forceBoth     = 1'b0;
        bus.enable    = 1'b0;
        bus.pwm_cmd   = 1'b0;
        bus.fault_in  = 1'b0;
        bus.fault_clr = 1'b0;
        bus.dt_cfg    = '0;
        bus.dt_cfg_wr = 1'b0;
        test_reset();
        test_dt_clamp();
        test_boot();
        test_pwm_deadtime();
        test_dt_shadow();
        test_stop();
        test_fault_external();
        test_shoot_through();
        test_watchdog();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
